// File: rtl/ram_access_pkg.sv
// Shared types for the RAM access controller: FSM state encoding and request word sizing.
package ram_access_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RELEASE = 2'd2
    } ram_access_state_t;

    // The request word stored in the FIFO is {write, address, data}.
    function automatic int request_width(input int address_width, input int data_width);
        return 1 + address_width + data_width;
    endfunction

endpackage

// File: rtl/memory_interface.sv
// Level-held RAM protocol: enable stays high until functionComplete, then drops for a cycle.
interface MemoryInterface #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 16
);
    logic [ADDRESS_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0]    dataOut;
    logic [DATA_WIDTH-1:0]    dataIn;
    logic                     readEnabled;
    logic                     writeEnabled;
    logic                     functionComplete;

    modport master (
        output address, dataOut, readEnabled, writeEnabled,
        input  dataIn, functionComplete
    );

    modport slave (
        input  address, dataOut, readEnabled, writeEnabled,
        output dataIn, functionComplete
    );
endinterface

// File: rtl/ram_access_controller_fifo.sv
// Synchronous show-ahead FIFO with occupancy counter and full/empty flags.
module request_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] writeData,
    output logic [DATA_WIDTH-1:0] readData,
    output logic                  full,
    output logic                  empty
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] storage [FIFO_DEPTH];
    logic [PTR_W-1:0]      writePointer;
    logic [PTR_W-1:0]      readPointer;
    logic [PTR_W:0]        count;
    logic                  doPush;
    logic                  doPop;

    assign doPush = push && !full;
    assign doPop  = pop && !empty;

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            writePointer <= '0;
            readPointer  <= '0;
            count        <= '0;
        end else begin
            if (doPush)
                writePointer <= writePointer + 1'b1;
            if (doPop)
                readPointer <= readPointer + 1'b1;
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (doPush)
            storage[writePointer] <= writeData;
    end

    assign readData = storage[readPointer];
    assign full     = (count == (PTR_W + 1)'(FIFO_DEPTH));
    assign empty    = (count == '0);

endmodule

// File: rtl/ram_access_controller.sv
// Converts a valid/ready request stream into the RAM's level-held enable protocol,
// one response per request in order, with range and timeout errors.
module ram_access_controller
    import ram_access_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = 16,
    parameter int DATA_WIDTH     = 16,
    parameter int SIZE_IN_WORDS  = 1024,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     requestValid,
    output logic                     requestReady,
    input  logic                     requestWrite,
    input  logic [ADDRESS_WIDTH-1:0] requestAddress,
    input  logic [DATA_WIDTH-1:0]    requestData,
    output logic                     responseValid,
    input  logic                     responseReady,
    output logic [DATA_WIDTH-1:0]    responseData,
    output logic                     responseWrite,
    output logic                     responseError,
    MemoryInterface.master           memoryInterface
);
    localparam int REQ_W   = request_width(ADDRESS_WIDTH, DATA_WIDTH);
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [ADDRESS_WIDTH:0] SIZE_LIMIT = (ADDRESS_WIDTH + 1)'(SIZE_IN_WORDS);
    localparam logic [TIMER_W-1:0]     TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    typedef struct packed {
        logic                     write;
        logic [ADDRESS_WIDTH-1:0] address;
        logic [DATA_WIDTH-1:0]    data;
    } request_t;

    ram_access_state_t        state;
    ram_access_state_t        nextState;
    request_t                 pushWord;
    request_t                 head;
    logic [REQ_W-1:0]         headBits;
    logic                     fifoFull;
    logic                     fifoEmpty;
    logic                     acceptEnabled;
    logic                     popRequest;
    logic                     headInRange;
    logic                     startAccess;
    logic                     finishAccess;
    logic                     timeoutAccess;
    logic                     loadError;
    logic [TIMER_W-1:0]       timer;
    logic [ADDRESS_WIDTH-1:0] addressReg;
    logic [DATA_WIDTH-1:0]    dataOutReg;
    logic                     readEnabledReg;
    logic                     writeEnabledReg;

    // Ready stays low until the first edge after reset release.
    assign requestReady = acceptEnabled && !fifoFull;
    assign pushWord     = '{write: requestWrite, address: requestAddress, data: requestData};
    assign head         = request_t'(headBits);

    request_fifo #(
        .DATA_WIDTH (REQ_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) requestQueue (
        .clock     (clock),
        .reset     (reset),
        .push      (requestValid && requestReady),
        .pop       (popRequest),
        .writeData (pushWord),
        .readData  (headBits),
        .full      (fifoFull),
        .empty     (fifoEmpty)
    );

    // A new request may only leave the FIFO when the single response slot is free or being freed.
    assign popRequest  = (state == IDLE || state == RELEASE) && !fifoEmpty
                         && (!responseValid || responseReady);
    assign headInRange = ({1'b0, head.address} < SIZE_LIMIT);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= nextState;
    end

    always_comb begin
        nextState     = state;
        startAccess   = 1'b0;
        finishAccess  = 1'b0;
        timeoutAccess = 1'b0;
        loadError     = 1'b0;
        unique case (state)
            IDLE, RELEASE: begin
                nextState = IDLE;
                if (popRequest) begin
                    if (headInRange) begin
                        nextState   = ACCESS;
                        startAccess = 1'b1;
                    end else begin
                        loadError = 1'b1;
                    end
                end
            end
            ACCESS: begin
                if (memoryInterface.functionComplete) begin
                    finishAccess = 1'b1;
                    nextState    = RELEASE;
                end else if (timer == TIMER_LAST) begin
                    timeoutAccess = 1'b1;
                    nextState     = RELEASE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acceptEnabled   <= 1'b0;
            timer           <= '0;
            addressReg      <= '0;
            dataOutReg      <= '0;
            readEnabledReg  <= 1'b0;
            writeEnabledReg <= 1'b0;
            responseValid   <= 1'b0;
            responseData    <= '0;
            responseWrite   <= 1'b0;
            responseError   <= 1'b0;
        end else begin
            acceptEnabled <= 1'b1;
            if (responseValid && responseReady)
                responseValid <= 1'b0;
            if (startAccess) begin
                addressReg      <= head.address;
                dataOutReg      <= head.data;
                writeEnabledReg <= head.write;
                readEnabledReg  <= !head.write;
                timer           <= '0;
            end
            if (state == ACCESS)
                timer <= timer + 1'b1;
            // The write flag of the in-flight access is carried by writeEnabledReg.
            if (finishAccess || timeoutAccess) begin
                responseValid   <= 1'b1;
                responseError   <= timeoutAccess;
                responseWrite   <= writeEnabledReg;
                responseData    <= (finishAccess && !writeEnabledReg) ? memoryInterface.dataIn : '0;
                readEnabledReg  <= 1'b0;
                writeEnabledReg <= 1'b0;
            end
            if (loadError) begin
                responseValid <= 1'b1;
                responseError <= 1'b1;
                responseWrite <= head.write;
                responseData  <= '0;
            end
        end
    end

    assign memoryInterface.address      = addressReg;
    assign memoryInterface.dataOut      = dataOutReg;
    assign memoryInterface.readEnabled  = readEnabledReg;
    assign memoryInterface.writeEnabled = writeEnabledReg;

endmodule

// File: tb/tb_ram_access_controller.sv
// Scoreboard bench for ram_access_controller against a DELAY=4 behavioural RAM.
module tb_ram_access_controller;
    import ram_access_pkg::*;

    localparam int AW    = 16;
    localparam int DW    = 16;
    localparam int DELAY = 4;

    typedef struct packed {
        logic          write;
        logic          error;
        logic [DW-1:0] data;
    } resp_t;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          requestValid = 1'b0;
    logic          requestReady;
    logic          requestWrite = 1'b0;
    logic [AW-1:0] requestAddress = '0;
    logic [DW-1:0] requestData = '0;
    logic          responseValid;
    logic          responseReady = 1'b1;
    logic [DW-1:0] responseData;
    logic          responseWrite;
    logic          responseError;
    logic          killComplete = 1'b0;

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int acceptCycle = 0;
    int riseCycle = 0;

    resp_t expQ[$];
    int    gapQ[$];
    int    runQ[$];

    logic [DW-1:0] ram [1024];
    int            ramCount = 0;
    logic          enabled;

    MemoryInterface #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) memBus ();

    ram_access_controller #(
        .ADDRESS_WIDTH  (AW),
        .DATA_WIDTH     (DW),
        .SIZE_IN_WORDS  (1024),
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .requestValid    (requestValid),
        .requestReady    (requestReady),
        .requestWrite    (requestWrite),
        .requestAddress  (requestAddress),
        .requestData     (requestData),
        .responseValid   (responseValid),
        .responseReady   (responseReady),
        .responseData    (responseData),
        .responseWrite   (responseWrite),
        .responseError   (responseError),
        .memoryInterface (memBus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cycle <= cycle + 1;

    // Behavioural RAM: completes after DELAY enable-high cycles, enable must drop to restart.
    assign enabled                 = memBus.readEnabled || memBus.writeEnabled;
    assign memBus.functionComplete = enabled && (ramCount == DELAY - 1) && !killComplete;
    assign memBus.dataIn           = ram[memBus.address[9:0]];

    always @(posedge clock) begin
        if (!enabled)
            ramCount <= 0;
        else if (ramCount < DELAY - 1)
            ramCount <= ramCount + 1;
        if (memBus.functionComplete && memBus.writeEnabled)
            ram[memBus.address[9:0]] <= memBus.dataOut;
    end

    // Monitor: response scoreboard plus enable run/gap tracking.
    logic prevEnHigh = 1'b0;
    logic seenHigh = 1'b0;
    logic prevRespValid = 1'b0;
    int   highRun = 0;
    int   lowRun = 0;

    always @(negedge clock) begin
        resp_t exp;
        if (reset) begin
            if (enabled) begin
                checks++;
                if (memBus.readEnabled && memBus.writeEnabled) begin
                    errors++;
                    $display("FAIL both_enables: read=%0b write=%0b, required one at a time",
                             memBus.readEnabled, memBus.writeEnabled);
                end
                if (!prevEnHigh && seenHigh)
                    gapQ.push_back(lowRun);
                highRun++;
                seenHigh = 1'b1;
            end else begin
                if (prevEnHigh) begin
                    runQ.push_back(highRun);
                    highRun = 0;
                    lowRun  = 0;
                end
                lowRun++;
            end
            prevEnHigh = enabled;
            if (responseValid && !prevRespValid)
                riseCycle = cycle;
            prevRespValid = responseValid;
            if (responseValid && responseReady) begin
                checks++;
                if (expQ.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_response: got w=%0b e=%0b d=0x%04h, required none",
                             responseWrite, responseError, responseData);
                end else begin
                    exp = expQ.pop_front();
                    if ({responseWrite, responseError, responseData} !== exp) begin
                        errors++;
                        $display("FAIL response: got w=%0b e=%0b d=0x%04h, required w=%0b e=%0b d=0x%04h",
                                 responseWrite, responseError, responseData,
                                 exp.write, exp.error, exp.data);
                    end
                end
            end
        end else begin
            prevEnHigh    = 1'b0;
            prevRespValid = 1'b0;
            highRun       = 0;
        end
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, actual, required);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic sendRequest(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                               input logic expErr, input logic [DW-1:0] expData);
        bit accepted = 1'b0;
        requestValid   = 1'b1;
        requestWrite   = w;
        requestAddress = a;
        requestData    = d;
        for (int i = 0; i < 300 && !accepted; i++) begin
            @(negedge clock);
            if (requestReady) begin
                accepted = 1'b1;
                expQ.push_back('{write: w, error: expErr, data: expData});
            end
            @(posedge clock);
            #1;
        end
        acceptCycle  = cycle;
        requestValid = 1'b0;
        if (!accepted) begin
            checks++;
            errors++;
            $display("FAIL request_accept: address 0x%04h not accepted within 300 cycles", a);
        end
    endtask

    task automatic waitDrain(input string name);
        int n = 0;
        while ((expQ.size() != 0 || responseValid) && n < 500) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (n >= 500) begin
            checks++;
            errors++;
            $display("FAIL drain_%s: %0d responses outstanding, required 0", name, expQ.size());
        end
    endtask

    task automatic waitValid(input string name, input int limit);
        int n = 0;
        @(negedge clock);
        while (!responseValid && n < limit) begin
            @(negedge clock);
            n++;
        end
        if (!responseValid) begin
            checks++;
            errors++;
            $display("FAIL %s: responseValid got 0 after %0d cycles, required 1", name, limit);
        end
    endtask

    initial begin
        int g0, r0, bad, a0;
        logic [DW-1:0] heldData;
        logic heldErr, heldWrite, stableBad, enBad;
        logic [DW-1:0] burstData [5];

        for (int i = 0; i < 1024; i++) ram[i] = '0;
        ram[16'h0001] = 16'hBEEF;
        for (int i = 0; i < 5; i++) ram[16'h0010 + i] = 16'h1000 + 16'(i);
        ram[16'h0020] = 16'h2000;
        ram[16'h0021] = 16'h2001;
        ram[16'h0030] = 16'h3000;
        burstData = '{16'h1000, 16'h1001, 16'h1002, 16'h1003, 16'h1004};

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check("reset_requestReady", 32'(requestReady), 0);
        check("reset_responseValid", 32'(responseValid), 0);
        check("reset_response_fields", {13'd0, responseWrite, responseError, responseData}, 0);
        check("reset_enables", {30'd0, memBus.readEnabled, memBus.writeEnabled}, 0);
        check("reset_address_dataOut", {memBus.address, memBus.dataOut}, 0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("release_requestReady", 32'(requestReady), 1);

        // 1: write then read back, with single-request latency
        sendRequest(1'b1, 16'h00A5, 16'h1234, 1'b0, 16'h0000);
        waitDrain("write");
        repeat (3) @(posedge clock);
        #1;
        sendRequest(1'b0, 16'h00A5, 16'h0000, 1'b0, 16'h1234);
        a0 = acceptCycle;
        waitDrain("read");
        check("read_latency", 32'(riseCycle - a0), 5);

        // 2: five back-to-back reads fill the FIFO
        g0 = gapQ.size();
        r0 = runQ.size();
        for (int i = 0; i < 5; i++)
            sendRequest(1'b0, 16'h0010 + 16'(i), 16'h0000, 1'b0, burstData[i]);
        @(negedge clock);
        check("burst_full_ready", 32'(requestReady), 0);
        @(posedge clock);
        #1;
        waitDrain("burst");
        check("burst_gap_count", 32'(gapQ.size() - g0), 5);
        bad = 0;
        for (int i = g0 + 1; i < gapQ.size(); i++)
            if (gapQ[i] != 1) bad++;
        check("burst_gaps_one_cycle", 32'(bad), 0);
        check("burst_run_count", 32'(runQ.size() - r0), 5);
        bad = 0;
        for (int i = r0; i < runQ.size(); i++)
            if (runQ[i] != DELAY) bad++;
        check("burst_runs_delay", 32'(bad), 0);

        // 3: out-of-range read, then a good read behind it
        r0 = runQ.size();
        sendRequest(1'b0, 16'h0400, 16'h0000, 1'b1, 16'h0000);
        sendRequest(1'b0, 16'h0001, 16'h0000, 1'b0, 16'hBEEF);
        waitDrain("range");
        check("range_single_access", 32'(runQ.size() - r0), 1);

        // 4: response back-pressure with two reads queued
        responseReady = 1'b0;
        sendRequest(1'b0, 16'h0020, 16'h0000, 1'b0, 16'h2000);
        sendRequest(1'b0, 16'h0021, 16'h0000, 1'b0, 16'h2001);
        waitValid("hold_first_valid", 100);
        heldData  = responseData;
        heldErr   = responseError;
        heldWrite = responseWrite;
        stableBad = 1'b0;
        enBad     = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (!responseValid || responseData !== heldData || responseError !== heldErr
                || responseWrite !== heldWrite)
                stableBad = 1'b1;
            if (enabled)
                enBad = 1'b1;
        end
        check("hold_outputs_stable", 32'(stableBad), 0);
        check("hold_no_enable", 32'(enBad), 0);
        check("hold_data", 32'(heldData), 32'h2000);
        @(posedge clock);
        #1;
        responseReady = 1'b1;
        @(posedge clock);
        #1;
        check("hold_release_issue", 32'(memBus.readEnabled), 1);
        waitDrain("hold");

        // 5: timeout on a read that never completes
        killComplete = 1'b1;
        r0 = runQ.size();
        sendRequest(1'b0, 16'h0030, 16'h0000, 1'b1, 16'h0000);
        waitValid("timeout_valid", 200);
        check("timeout_state_release", 32'(dut.state), 32'(RELEASE));
        waitDrain("timeout");
        killComplete = 1'b0;
        check("timeout_run_count", 32'(runQ.size() - r0), 1);
        if (runQ.size() > r0)
            check("timeout_enable_cycles", 32'(runQ[r0]), 64);

        // 6: reset in the middle of a write with another request queued
        sendRequest(1'b1, 16'h0050, 16'h5555, 1'b0, 16'h0000);
        sendRequest(1'b0, 16'h0001, 16'h0000, 1'b0, 16'hBEEF);
        bad = 0;
        while (!memBus.writeEnabled && bad < 50) begin
            @(negedge clock);
            bad++;
        end
        check("midwrite_started", 32'(memBus.writeEnabled), 1);
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("reset_async_enables", {30'd0, memBus.readEnabled, memBus.writeEnabled}, 0);
        expQ.delete();
        repeat (2) @(posedge clock);
        #1;
        check("inreset_requestReady", 32'(requestReady), 0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("postreset_fifo_empty", 32'(dut.requestQueue.empty), 1);
        check("postreset_responseValid", 32'(responseValid), 0);
        enBad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (enabled || responseValid)
                enBad = 1'b1;
        end
        check("postreset_idle", 32'(enBad), 0);
        check("postreset_write_discarded", 32'(ram[16'h0050]), 0);
        @(posedge clock);
        #1;
        sendRequest(1'b0, 16'h00A5, 16'h0000, 1'b0, 16'h1234);
        waitDrain("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
